// File: rtl/csr_pkg.sv
// Purpose : shared opcodes, counter CSR addresses and the counter-select enum
//           for the CSR counter front end.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package csr_pkg;

  // Major opcode and funct3 values used by the counter-read decode.
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_PRIV    = 3'b000;   // ECALL/EBREAK/xRET space, never a CSR access
  localparam logic [2:0] F3_CSRRS   = 3'b010;

  // User-level read-only counter CSR addresses.
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  // Select driven to the counter block: which 32-bit half of which counter.
  typedef enum logic [1:0] {
    SEL_CYC_LO = 2'd0,
    SEL_RET_LO = 2'd1,
    SEL_CYC_HI = 2'd2,
    SEL_RET_HI = 2'd3
  } csr_sel_t;

endpackage

// File: rtl/csr_pipe_ctrl_decode.sv
// Purpose : combinational decode of one instruction into a counter-read
//           request {csr_rd, ctrl} or an unsupported-CSR flag.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports   : i_inst      instruction word
//           o_csr_rd    instruction is a supported counter read (CSRRS, rs1=x0)
//           o_ctrl      counter select, SEL_CYC_LO when o_csr_rd is 0
//           o_illegal   SYSTEM CSR access (funct3 != 0) that is not a supported read
// Config  : CSR_TIME_ALIAS_EN - also accept time/timeh, aliased onto the cycle counter.
module csr_decode
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_inst,
  output logic            o_csr_rd,
  output csr_sel_t        o_ctrl,
  output logic            o_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [11:0] w_addr;
  logic        w_system;
  logic        w_hit;
  csr_sel_t    w_sel;
  // rd is extracted by the pipeline itself, not needed for the decode.
  logic        w_unused_rd;

  assign w_opcode    = i_inst[6:0];
  assign w_funct3    = i_inst[14:12];
  assign w_rs1       = i_inst[19:15];
  assign w_addr      = i_inst[31:20];
  assign w_system    = (w_opcode == OPC_SYSTEM);
  assign w_unused_rd = ^i_inst[11:7];

  // Address lookup: which counter half an address names, if any.
  always_comb begin
    w_hit = 1'b0;
    w_sel = SEL_CYC_LO;
    case (w_addr)
      CSR_CYCLE:    begin w_hit = 1'b1; w_sel = SEL_CYC_LO; end
      CSR_INSTRET:  begin w_hit = 1'b1; w_sel = SEL_RET_LO; end
      CSR_CYCLEH:   begin w_hit = 1'b1; w_sel = SEL_CYC_HI; end
      CSR_INSTRETH: begin w_hit = 1'b1; w_sel = SEL_RET_HI; end
`ifdef CSR_TIME_ALIAS_EN
      // No separate timer exists; time reads return the cycle counter.
      CSR_TIME:     begin w_hit = 1'b1; w_sel = SEL_CYC_LO; end
      CSR_TIMEH:    begin w_hit = 1'b1; w_sel = SEL_CYC_HI; end
`else
      // Without the alias, time/timeh decode as unsupported accesses.
      CSR_TIME, CSR_TIMEH: w_hit = 1'b0;
`endif
      default:      w_hit = 1'b0;
    endcase
  end

  // Only the pure read form (CSRRS with rs1=x0) is supported; any other CSR
  // op on SYSTEM, including a write-capable form on a counter address, is illegal.
  always_comb begin
    o_csr_rd  = 1'b0;
    o_ctrl    = SEL_CYC_LO;
    o_illegal = 1'b0;
    if (w_system && (w_funct3 != F3_PRIV)) begin
      if ((w_funct3 == F3_CSRRS) && (w_rs1 == 5'd0) && w_hit) begin
        o_csr_rd = 1'b1;
        o_ctrl   = w_sel;
      end else begin
        o_illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_pipe_ctrl.sv
// Purpose : decodes counter CSR reads in ID and carries them through the
//           ID/EX and EX/MEM registers, producing the counter select and retire pulse.
// Latency : ID_EX_* 1 cycle after IF_ID_inst is sampled, EX_MEM_* 2 cycles.
// Backpressure: stall holds ID/EX and injects a bubble into EX/MEM; flush kills
//           ID/EX and also bubbles EX/MEM, and wins over stall.
// Ports   : clk/rst (async active-high); IF_ID_inst/IF_ID_valid from ID;
//           stall/flush hazard controls; ID_EX_* and EX_MEM_* stage outputs;
//           illegal_csr one-cycle pulse when an unsupported CSR access enters ID/EX.
// Config  : CSR_TIME_ALIAS_EN (see csr_decode).
module csr_pipe_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IF_ID_inst,
  input  logic            IF_ID_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [1:0]      ID_EX_CSR_ctrl,
  output logic            ID_EX_csr_rd,
  output logic [RD_W-1:0] ID_EX_rd,
  output logic            ID_EX_inst_add1,
  output logic [1:0]      EX_MEM_CSR_ctrl,
  output logic            EX_MEM_csr_rd,
  output logic [RD_W-1:0] EX_MEM_rd,
  output logic            EX_MEM_inst_add1,
  output logic            illegal_csr
);

  // Decode outputs for the instruction currently in ID.
  logic      w_dec_csr_rd;
  csr_sel_t  w_dec_ctrl;
  logic      w_dec_illegal;
  logic      w_ld_csr_rd;
  csr_sel_t  w_ld_ctrl;
  logic      w_id_load;

  // ID/EX stage.
  logic            r_id_ex_valid;
  logic            r_id_ex_csr_rd;
  csr_sel_t        r_id_ex_ctrl;
  logic [RD_W-1:0] r_id_ex_rd;
  logic            r_illegal;

  // EX/MEM stage.
  logic            r_ex_mem_valid;
  logic            r_ex_mem_csr_rd;
  csr_sel_t        r_ex_mem_ctrl;
  logic [RD_W-1:0] r_ex_mem_rd;

  csr_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_inst    (IF_ID_inst),
    .o_csr_rd  (w_dec_csr_rd),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal)
  );

  // A bubble in ID must never request a counter read, whatever its bits say.
  assign w_ld_csr_rd = IF_ID_valid & w_dec_csr_rd;
  assign w_ld_ctrl   = w_ld_csr_rd ? w_dec_ctrl : SEL_CYC_LO;
  assign w_id_load   = ~flush & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_ex_valid  <= 1'b0;
      r_id_ex_csr_rd <= 1'b0;
      r_id_ex_ctrl   <= SEL_CYC_LO;
      r_id_ex_rd     <= '0;
      r_illegal      <= 1'b0;
    end else begin
      if (flush) begin
        r_id_ex_valid  <= 1'b0;
        r_id_ex_csr_rd <= 1'b0;
        r_id_ex_ctrl   <= SEL_CYC_LO;
        r_id_ex_rd     <= '0;
      end else if (!stall) begin
        r_id_ex_valid  <= IF_ID_valid;
        r_id_ex_csr_rd <= w_ld_csr_rd;
        r_id_ex_ctrl   <= w_ld_ctrl;
        r_id_ex_rd     <= IF_ID_inst[7 +: RD_W];
      end
      // Pulse only on the actual capture, so a stalled illegal op reports once.
      r_illegal <= w_id_load & IF_ID_valid & w_dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_mem_valid  <= 1'b0;
      r_ex_mem_csr_rd <= 1'b0;
      r_ex_mem_ctrl   <= SEL_CYC_LO;
      r_ex_mem_rd     <= '0;
    end else if (stall || flush) begin
      // The ID/EX occupant either stays put or dies, so EX/MEM receives nothing.
      r_ex_mem_valid  <= 1'b0;
      r_ex_mem_csr_rd <= 1'b0;
      r_ex_mem_ctrl   <= SEL_CYC_LO;
      r_ex_mem_rd     <= '0;
    end else begin
      r_ex_mem_valid  <= r_id_ex_valid;
      r_ex_mem_csr_rd <= r_id_ex_csr_rd;
      r_ex_mem_ctrl   <= r_id_ex_ctrl;
      r_ex_mem_rd     <= r_id_ex_rd;
    end
  end

  // Retire exactly when the ID/EX occupant moves on: never while held by a
  // stall (so it counts once) and never when squashed as wrong-path.
  assign ID_EX_inst_add1  = r_id_ex_valid & ~stall & ~flush;

  assign ID_EX_CSR_ctrl   = r_id_ex_ctrl;
  assign ID_EX_csr_rd     = r_id_ex_csr_rd;
  assign ID_EX_rd         = r_id_ex_rd;
  assign EX_MEM_CSR_ctrl  = r_ex_mem_ctrl;
  assign EX_MEM_csr_rd    = r_ex_mem_csr_rd;
  assign EX_MEM_rd        = r_ex_mem_rd;
  assign EX_MEM_inst_add1 = r_ex_mem_valid;
  assign illegal_csr      = r_illegal;

endmodule

// File: tb/tb_csr_pipe_ctrl.sv
// Bench for csr_pipe_ctrl: directed vector table, multi-cycle corner
// sequences, then random traffic against a slot-level reference model.
module tb_csr_pipe_ctrl;

  localparam int RD_W = 5;
`ifdef CSR_TIME_ALIAS_EN
  localparam bit TIME_ALIAS = 1'b1;
`else
  localparam bit TIME_ALIAS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     IF_ID_inst;
  logic            IF_ID_valid;
  logic            stall;
  logic            flush;
  logic [1:0]      ID_EX_CSR_ctrl;
  logic            ID_EX_csr_rd;
  logic [RD_W-1:0] ID_EX_rd;
  logic            ID_EX_inst_add1;
  logic [1:0]      EX_MEM_CSR_ctrl;
  logic            EX_MEM_csr_rd;
  logic [RD_W-1:0] EX_MEM_rd;
  logic            EX_MEM_inst_add1;
  logic            illegal_csr;

  csr_pipe_ctrl #(.XLEN(32), .RD_W(RD_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .IF_ID_inst       (IF_ID_inst),
    .IF_ID_valid      (IF_ID_valid),
    .stall            (stall),
    .flush            (flush),
    .ID_EX_CSR_ctrl   (ID_EX_CSR_ctrl),
    .ID_EX_csr_rd     (ID_EX_csr_rd),
    .ID_EX_rd         (ID_EX_rd),
    .ID_EX_inst_add1  (ID_EX_inst_add1),
    .EX_MEM_CSR_ctrl  (EX_MEM_CSR_ctrl),
    .EX_MEM_csr_rd    (EX_MEM_csr_rd),
    .EX_MEM_rd        (EX_MEM_rd),
    .EX_MEM_inst_add1 (EX_MEM_inst_add1),
    .illegal_csr      (illegal_csr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic s, input logic f);
    IF_ID_inst  = ins;
    IF_ID_valid = v;
    stall       = s;
    flush       = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ID_EX_CSR_ctrl"},   32'(ID_EX_CSR_ctrl),   0);
    chk({tag, " ID_EX_csr_rd"},     32'(ID_EX_csr_rd),     0);
    chk({tag, " ID_EX_rd"},         32'(ID_EX_rd),         0);
    chk({tag, " ID_EX_inst_add1"},  32'(ID_EX_inst_add1),  0);
    chk({tag, " EX_MEM_CSR_ctrl"},  32'(EX_MEM_CSR_ctrl),  0);
    chk({tag, " EX_MEM_csr_rd"},    32'(EX_MEM_csr_rd),    0);
    chk({tag, " EX_MEM_rd"},        32'(EX_MEM_rd),        0);
    chk({tag, " EX_MEM_inst_add1"}, 32'(EX_MEM_inst_add1), 0);
    chk({tag, " illegal_csr"},      32'(illegal_csr),      0);
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic void ref_dec(input logic [31:0] ins, output bit ok,
                                  output logic [1:0] sel, output bit ill);
    bit known;
    known = 1'b1;
    sel   = 2'd0;
    case (ins[31:20])
      12'hC00: sel = 2'd0;
      12'hC02: sel = 2'd1;
      12'hC80: sel = 2'd2;
      12'hC82: sel = 2'd3;
      12'hC01: begin known = TIME_ALIAS; sel = 2'd0; end
      12'hC81: begin known = TIME_ALIAS; sel = 2'd2; end
      default: known = 1'b0;
    endcase
    ok  = (ins[6:0] == 7'h73) && (ins[14:12] == 3'b010) && (ins[19:15] == 5'd0) && known;
    ill = (ins[6:0] == 7'h73) && (ins[14:12] != 3'b000) && !ok;
    if (!ok) sel = 2'd0;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        e_csr;
    logic [1:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic        e_ill;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic       csr;
    logic [1:0] ctrl;
    logic [4:0] rd;
  } slot_t;

  localparam int NV = 14;
  vec_t  vecs [NV];
  slot_t m_idex, m_exm, n_idex;
  bit    m_ill;
  int    pulses;

  function automatic logic [31:0] rand_inst();
    logic [11:0] addrs [6];
    logic [31:0] r;
    int k;
    addrs[0] = 12'hC00; addrs[1] = 12'hC01; addrs[2] = 12'hC02;
    addrs[3] = 12'hC80; addrs[4] = 12'hC81; addrs[5] = 12'hC82;
    k = $urandom_range(0, 5);
    r = $urandom;
    case (k)
      0: rand_inst = {addrs[$urandom_range(0, 5)], 5'd0, 3'b010, r[11:7], 7'h73};
      1: rand_inst = {addrs[$urandom_range(0, 5)], r[19:15], 3'b010, r[11:7], 7'h73};
      2: rand_inst = {(r[0] ? addrs[$urandom_range(0, 5)] : r[31:20]), r[19:15],
                      3'($urandom_range(0, 7)), r[11:7], 7'h73};
      3: rand_inst = r;
      4: rand_inst = {r[31:20], r[19:15], 3'b000, r[11:7], 7'h13};
      default: rand_inst = {r[31:20], 5'd0, 3'b000, r[11:7], 7'h73};
    endcase
  endfunction

  initial begin
    bit ok, ill;
    logic [1:0] sel;
    logic [31:0] ins;
    logic v, s, f;

    // Directed table: {inst, valid, csr_rd, ctrl, rd, illegal} after one edge.
    vecs[0]  = '{32'hC0002573, 1'b1, 1'b1, 2'd0, 5'd10, 1'b0}; // rdcycle a0
    vecs[1]  = '{32'hC0202573, 1'b1, 1'b1, 2'd1, 5'd10, 1'b0}; // rdinstret
    vecs[2]  = '{32'hC8002573, 1'b1, 1'b1, 2'd2, 5'd10, 1'b0}; // rdcycleh
    vecs[3]  = '{32'hC8202573, 1'b1, 1'b1, 2'd3, 5'd10, 1'b0}; // rdinstreth
    vecs[4]  = '{32'hC0102573, 1'b1, TIME_ALIAS, 2'd0, 5'd10, !TIME_ALIAS}; // rdtime
    vecs[5]  = '{32'hC8102573, 1'b1, TIME_ALIAS, TIME_ALIAS ? 2'd2 : 2'd0, 5'd10, !TIME_ALIAS};
    vecs[6]  = '{32'h00100293, 1'b1, 1'b0, 2'd0, 5'd5,  1'b0}; // addi x5,x0,1
    vecs[7]  = '{32'hC0002573, 1'b0, 1'b0, 2'd0, 5'd10, 1'b0}; // bubble, matching bits
    vecs[8]  = '{32'hC000A573, 1'b1, 1'b0, 2'd0, 5'd10, 1'b1}; // csrrs rs1=x1
    vecs[9]  = '{32'hC0001573, 1'b1, 1'b0, 2'd0, 5'd10, 1'b1}; // csrrw cycle
    vecs[10] = '{32'h00000073, 1'b1, 1'b0, 2'd0, 5'd0,  1'b0}; // ecall
    vecs[11] = '{32'h30002573, 1'b1, 1'b0, 2'd0, 5'd10, 1'b1}; // csrr mstatus
    vecs[12] = '{32'hC0006573, 1'b1, 1'b0, 2'd0, 5'd10, 1'b1}; // csrrsi cycle
    vecs[13] = '{32'hC82025F3, 1'b1, 1'b1, 2'd3, 5'd11, 1'b0}; // rdinstreth a1

    // Reset state.
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    chk("no pulse at reset release", 32'(ID_EX_inst_add1), 0);
    tick();

    // Table: each vector is checked in ID/EX one edge later and in EX/MEM two edges later.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].inst, vecs[i].valid, 1'b0, 1'b0);
      if (i > 0) begin
        @(negedge clk);
        chk($sformatf("v%0d inst_add1", i - 1), 32'(ID_EX_inst_add1), 32'(vecs[i-1].valid));
      end
      tick();
      chk($sformatf("v%0d ID_EX_csr_rd", i), 32'(ID_EX_csr_rd), 32'(vecs[i].e_csr));
      if (vecs[i].valid)
        chk($sformatf("v%0d ID_EX_CSR_ctrl", i), 32'(ID_EX_CSR_ctrl), 32'(vecs[i].e_ctrl));
      chk($sformatf("v%0d ID_EX_rd", i), 32'(ID_EX_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d illegal_csr", i), 32'(illegal_csr), 32'(vecs[i].e_ill));
      if (i > 0) begin
        chk($sformatf("v%0d EX_MEM_csr_rd", i - 1), 32'(EX_MEM_csr_rd), 32'(vecs[i-1].e_csr));
        chk($sformatf("v%0d EX_MEM_rd", i - 1), 32'(EX_MEM_rd), 32'(vecs[i-1].e_rd));
        chk($sformatf("v%0d EX_MEM_inst_add1", i - 1), 32'(EX_MEM_inst_add1), 32'(vecs[i-1].valid));
        if (vecs[i-1].valid)
          chk($sformatf("v%0d EX_MEM_CSR_ctrl", i - 1), 32'(EX_MEM_CSR_ctrl), 32'(vecs[i-1].e_ctrl));
      end
    end

    // Stall: addi held for 3 cycles, counted exactly once.
    drive(32'h00100293, 1'b1, 1'b0, 1'b0);
    tick();
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      drive(32'hC0002573, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("stall inst_add1", 32'(ID_EX_inst_add1), 0);
      pulses += int'(ID_EX_inst_add1);
      tick();
      chk("stall ID_EX_rd held", 32'(ID_EX_rd), 5);
      chk("stall EX_MEM bubble", 32'(EX_MEM_inst_add1), 0);
    end
    drive(32'hC0002573, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("release inst_add1", 32'(ID_EX_inst_add1), 1);
    pulses += int'(ID_EX_inst_add1);
    chk("stall total retire pulses", 32'(pulses), 1);
    tick();
    chk("release EX_MEM_rd", 32'(EX_MEM_rd), 5);
    chk("release EX_MEM_inst_add1", 32'(EX_MEM_inst_add1), 1);

    // Stall and flush together with a valid ID/EX: flush wins.
    drive(32'hC0202573, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall+flush inst_add1", 32'(ID_EX_inst_add1), 0);
    tick();
    chk("stall+flush ID_EX_csr_rd", 32'(ID_EX_csr_rd), 0);
    chk("stall+flush ID_EX_rd", 32'(ID_EX_rd), 0);
    chk("stall+flush EX_MEM_inst_add1", 32'(EX_MEM_inst_add1), 0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("after flush ID_EX invalid", 32'(ID_EX_inst_add1), 0);
    tick();

    // Asynchronous reset while an instruction is held by a stall.
    drive(32'hC0002573, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'hC0002573, 1'b1, 1'b1, 1'b0);
    tick();
    chk("held csr_rd before reset", 32'(ID_EX_csr_rd), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    rst = 1'b0;
    drive(32'hC0002573, 1'b0, 1'b0, 1'b0);
    #1;
    chk("deassert cycle inst_add1", 32'(ID_EX_inst_add1), 0);
    tick();
    chk("bubble csr_rd", 32'(ID_EX_csr_rd), 0);
    chk("bubble illegal", 32'(illegal_csr), 0);
    @(negedge clk);
    chk("bubble inst_add1", 32'(ID_EX_inst_add1), 0);

    // Random traffic against the slot model.
    do_reset();
    m_idex = '0;
    m_exm  = '0;
    m_ill  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      ins = rand_inst();
      v   = ($urandom_range(0, 9) < 8);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 9) == 0);
      drive(ins, v, s, f);
      @(negedge clk);
      chk("rnd inst_add1", 32'(ID_EX_inst_add1), 32'(m_idex.v && !s && !f));

      ref_dec(ins, ok, sel, ill);
      if (f)      n_idex = '0;
      else if (s) n_idex = m_idex;
      else        n_idex = '{v: v, csr: v && ok, ctrl: (v && ok) ? sel : 2'd0, rd: ins[11:7]};
      m_exm  = (s || f) ? slot_t'('0) : m_idex;
      m_idex = n_idex;
      m_ill  = !f && !s && v && ill;

      tick();
      chk("rnd ID_EX_csr_rd", 32'(ID_EX_csr_rd), 32'(m_idex.csr));
      chk("rnd ID_EX_rd", 32'(ID_EX_rd), 32'(m_idex.rd));
      if (m_idex.csr) chk("rnd ID_EX_CSR_ctrl", 32'(ID_EX_CSR_ctrl), 32'(m_idex.ctrl));
      chk("rnd illegal_csr", 32'(illegal_csr), 32'(m_ill));
      chk("rnd EX_MEM_inst_add1", 32'(EX_MEM_inst_add1), 32'(m_exm.v));
      chk("rnd EX_MEM_csr_rd", 32'(EX_MEM_csr_rd), 32'(m_exm.csr));
      chk("rnd EX_MEM_rd", 32'(EX_MEM_rd), 32'(m_exm.rd));
      if (m_exm.csr) chk("rnd EX_MEM_CSR_ctrl", 32'(EX_MEM_CSR_ctrl), 32'(m_exm.ctrl));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
